quiz_round_ctrl: RTL
====================

Name: quiz_round_ctrl

Overview:
- Round sequencer for the multichannel answering machine; sits downstream of the settings block.
- Latches the game settings once configuration completes, then runs buzz-in rounds.
- Arbitrates up to 4 player buzzers, times the answer window, and applies host judgement to per-player scores.
- Drives the seven-segment, light and speaker logic.

Parameters:
- TICK_CYCLES, 100000000: clk cycles per one-second tick.
- SCORE_W, 8: width of each signed player score.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_done  in  1  level; settings valid (from the settings block's set-over flag).
- num_people  in  6  player count, 2..4.
- count_seconds  in  6  window length in seconds, >=1.
- correct_point  in  6  points added on a correct answer.
- mistake_point  in  6  points subtracted on a wrong answer or timeout.
- start_btn  in  1  host opens a round.
- buzz  in  4  player buzzers, bit i = player i.
- judge_ok  in  1  host: correct.
- judge_bad  in  1  host: wrong.
- state  out  2  0 IDLE, 1 READY, 2 OPEN, 3 ANSWER.
- winner_valid  out  1  a winner is held.
- winner_id  out  2  index of the winning player.
- seconds_left  out  6  countdown value.
- scores  out  4*SCORE_W  player i occupies [i*SCORE_W +: SCORE_W].
- timeout_pulse  out  1  one-cycle pulse on window expiry.
- speaker_en  out  1  high while in ANSWER.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and internal registers go to 0, state = IDLE.
- Buttons (start_btn, buzz, judge_ok, judge_bad) are registered once; their rising edges are used.
  - An event takes effect at the first clk edge after the registered rising edge.
- Latched config (np, cs, cp, mp) is sampled only on the IDLE->READY transition.
- IDLE:
  - When cfg_done=1: latch config, clear all scores to 0, go to READY.
- cfg_done=0 in any non-IDLE state: go to IDLE next cycle.
  - winner_valid and seconds_left clear; scores are held.
- READY:
  - start edge: go to OPEN, seconds_left = cs, tick prescaler = 0, winner_valid = 0.
- OPEN:
  - Buzz edges from players with index >= np are ignored.
  - Eligible buzz: the lowest-index eligible player among edges in the same cycle wins.
  - On a win: winner_id and winner_valid=1 are set, seconds_left reloads to cs, the prescaler clears, go to ANSWER.
- Tick behaviour in OPEN and ANSWER:
  - The prescaler counts 0..TICK_CYCLES-1; its wrap is a tick.
  - On a tick, seconds_left decrements.
  - A tick while seconds_left==1 sets seconds_left=0 and asserts timeout_pulse.
- Timeout in OPEN: go to READY, no score change.
- Timeout in ANSWER: the winner's score -= mp, go to READY.
- ANSWER judgement:
  - judge_ok edge: winner's score += cp, go to READY.
  - judge_bad edge: winner's score -= mp, go to READY.
  - judge_ok and judge_bad edges in the same cycle: both ignored.
  - A judge edge in the same cycle as the expiring tick takes priority; no timeout_pulse is issued.
- After returning to READY, winner_valid and winner_id stay valid until the next start edge.
- Buzz edges in ANSWER and READY are ignored (READY: see the optional feature).
- Arithmetic:
  - Scores are two's complement and saturate to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1].
  - Points are zero-extended before the add or subtract.
- No state is ever entered with np outside 2..4; the upstream block guarantees the range.

Optional Feature:
- Macro: FALSE_START_EN.
- Defined:
  - An eligible buzz edge while in READY deducts mp from that player's score (saturating).
  - It also sets that player's lockout bit. Locked players are ineligible in the next OPEN.
  - Lockout bits clear when that round returns to READY.
  - Multiple simultaneous false starts are all penalised.
- Undefined: buzzes in READY are ignored and no lockout logic exists.

Test Plan:
- Setup for all scenarios: TICK_CYCLES=4, cfg np=3, cs=2, cp=5, mp=2, cfg_done=1.
- Start, buzz[1] edge, judge_ok -> winner_id=1, scores[1]=5, state returns to READY.
- Start, buzz=4'b0110 in the same cycle -> winner_id=1. Separately, buzz[3] alone -> ignored, state stays OPEN.
- Start, buzz[0], no judge for 8 cycles -> timeout_pulse once, scores[0]=-2, state READY. Start with no buzz for 8 cycles -> READY, scores unchanged.
- Penalise player 2 repeatedly with mp=63 (SCORE_W=8) -> score saturates at -128. Repeated cp=63 gains -> saturate at 127.
- Drop cfg_done mid-ANSWER -> IDLE next cycle, scores held. Assert rst low mid-OPEN -> all outputs 0 immediately, asynchronously.
- With FALSE_START_EN defined: buzz[0] in READY -> scores[0]=-2; next round buzz[0] is ignored and buzz[2] wins.

Source files
------------

// File: rtl/quiz_round_ctrl.sv
// Buzz-in round sequencer: latches game settings, arbitrates 4 buzzers, times the answer window, keeps scores.
// Optional macro FALSE_START_EN: penalise and lock out players who buzz before the round opens.
module quiz_round_ctrl #(
   parameter int TICK_CYCLES = 100000000,
   parameter int SCORE_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_done,
   input  logic [5:0]             num_people,
   input  logic [5:0]             count_seconds,
   input  logic [5:0]             correct_point,
   input  logic [5:0]             mistake_point,
   input  logic                   start_btn,
   input  logic [3:0]             buzz,
   input  logic                   judge_ok,
   input  logic                   judge_bad,
   output logic [1:0]             state,
   output logic                   winner_valid,
   output logic [1:0]             winner_id,
   output logic [5:0]             seconds_left,
   output logic [4*SCORE_W-1:0]   scores,
   output logic                   timeout_pulse,
   output logic                   speaker_en
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int EW = SCORE_W + 8;
   localparam logic signed [EW-1:0] SMAX = {{9{1'b0}}, {(SCORE_W-1){1'b1}}};
   localparam logic signed [EW-1:0] SMIN = {{9{1'b1}}, {(SCORE_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1, S_OPEN = 2'd2, S_ANSWER = 2'd3} state_t;
   state_t cur, nxt;

   logic start_r, start_p, ok_r, ok_p, bad_r, bad_p;
   logic [3:0] buzz_r, buzz_p;
   logic [5:0] np_q, cs_q, cp_q, mp_q;
   logic [PW-1:0] presc;
   logic [SCORE_W-1:0] score_q [4];
   logic start_e, ok_e, bad_e, judge_one, tick, expire, cfg_drop;
   logic [3:0] buzz_e, np_mask, eligible;
   logic do_win, do_timeout, do_add, do_sub, round_end;
`ifdef FALSE_START_EN
   logic [3:0] lock_q, fs_hit;
`endif

   function automatic logic [SCORE_W-1:0] sat_step(input logic [SCORE_W-1:0] s,
                                                    input logic [5:0] pts, input logic sub);
      logic signed [EW-1:0] r;
      r = sub ? (EW'($signed(s)) - EW'(pts)) : (EW'($signed(s)) + EW'(pts));
      if (r > SMAX)      return SMAX[SCORE_W-1:0];
      else if (r < SMIN) return SMIN[SCORE_W-1:0];
      else               return r[SCORE_W-1:0];
   endfunction

   // Button edges come from the registered copy, so an event acts one edge after it is seen.
   always_comb begin
      start_e   = start_r & ~start_p;
      buzz_e    = buzz_r & ~buzz_p;
      ok_e      = ok_r & ~ok_p;
      bad_e     = bad_r & ~bad_p;
      judge_one = ok_e ^ bad_e;
      tick      = (presc == PW'(TICK_CYCLES - 1));
      expire    = tick && (seconds_left == 6'd1);
      cfg_drop  = (cur != S_IDLE) && !cfg_done;
      for (int i = 0; i < 4; i++) np_mask[i] = (6'(i) < np_q);
`ifdef FALSE_START_EN
      eligible  = buzz_e & np_mask & ~lock_q;
      fs_hit    = (cur == S_READY && !cfg_drop) ? (buzz_e & np_mask) : 4'b0;
`else
      eligible  = buzz_e & np_mask;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur <= S_IDLE;
      else      cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      if (cfg_drop) nxt = S_IDLE;
      else begin
         case (cur)
            S_IDLE:   if (cfg_done) nxt = S_READY;
            S_READY:  if (start_e) nxt = S_OPEN;
            S_OPEN:   if (|eligible) nxt = S_ANSWER;
                      else if (expire) nxt = S_READY;
            S_ANSWER: if (judge_one || expire) nxt = S_READY;
            default:  nxt = S_IDLE;
         endcase
      end
   end

   // A win beats a same-cycle tick; a single judge beats the expiring tick.
   always_comb begin
      do_win     = (cur == S_OPEN) && !cfg_drop && (|eligible);
      do_timeout = !cfg_drop && expire &&
                   ((cur == S_OPEN && !(|eligible)) || (cur == S_ANSWER && !judge_one));
      do_add     = !cfg_drop && (cur == S_ANSWER) && ok_e && !bad_e;
      do_sub     = !cfg_drop && (cur == S_ANSWER) && ((bad_e && !ok_e) || (expire && !judge_one));
      round_end  = !cfg_drop && (cur == S_OPEN || cur == S_ANSWER) && (nxt == S_READY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {start_r, start_p, ok_r, ok_p, bad_r, bad_p} <= '0;
         buzz_r        <= '0;
         buzz_p        <= '0;
         {np_q, cs_q, cp_q, mp_q} <= '0;
         presc         <= '0;
         winner_valid  <= 1'b0;
         winner_id     <= 2'd0;
         seconds_left  <= 6'd0;
         timeout_pulse <= 1'b0;
         for (int i = 0; i < 4; i++) score_q[i] <= '0;
`ifdef FALSE_START_EN
         lock_q        <= '0;
`endif
      end else begin
         start_r <= start_btn;  start_p <= start_r;
         buzz_r  <= buzz;       buzz_p  <= buzz_r;
         ok_r    <= judge_ok;   ok_p    <= ok_r;
         bad_r   <= judge_bad;  bad_p   <= bad_r;
         timeout_pulse <= do_timeout;
         if (cfg_drop) begin
            winner_valid <= 1'b0;
            seconds_left <= 6'd0;
            presc        <= '0;
         end else begin
            case (cur)
               S_IDLE: if (cfg_done) begin
                  {np_q, cs_q, cp_q, mp_q} <= {num_people, count_seconds, correct_point, mistake_point};
                  for (int i = 0; i < 4; i++) score_q[i] <= '0;
`ifdef FALSE_START_EN
                  lock_q <= '0;
`endif
               end
               S_READY: begin
                  if (start_e) begin
                     seconds_left <= cs_q;
                     presc        <= '0;
                     winner_valid <= 1'b0;
                  end
`ifdef FALSE_START_EN
                  for (int i = 0; i < 4; i++)
                     if (fs_hit[i]) score_q[i] <= sat_step(score_q[i], mp_q, 1'b1);
                  lock_q <= lock_q | fs_hit;
`endif
               end
               default: begin
                  if (do_win) begin
                     for (int i = 3; i >= 0; i--)
                        if (eligible[i]) winner_id <= 2'(i);
                     winner_valid <= 1'b1;
                     seconds_left <= cs_q;
                     presc        <= '0;
                  end else begin
                     presc <= tick ? '0 : presc + PW'(1);
                     if (tick && seconds_left != 6'd0) seconds_left <= seconds_left - 6'd1;
                  end
                  if (do_add)      score_q[winner_id] <= sat_step(score_q[winner_id], cp_q, 1'b0);
                  else if (do_sub) score_q[winner_id] <= sat_step(score_q[winner_id], mp_q, 1'b1);
`ifdef FALSE_START_EN
                  if (round_end) lock_q <= '0;
`endif
               end
            endcase
         end
      end
   end

   // winner_valid is a level qualifier for winner_id; there is no ready/acknowledge side.
   always_comb begin
      state      = cur;
      speaker_en = (cur == S_ANSWER);
      for (int i = 0; i < 4; i++) scores[i*SCORE_W +: SCORE_W] = score_q[i];
   end

endmodule
